// File: rtl/async_fifo_wr_side.sv
// Write-domain half of an asynchronous FIFO: owns the storage array and the
// binary/Gray write pointer, synchronizes the read-domain Gray pointer and
// derives full, almost_full, level and a sticky overflow flag from it.
module async_fifo_wr_side #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 66,
    parameter int F_DEPTH    = 4,
    parameter int P_SIZE     = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 wr_valid,
    input  logic [BUS_WIDTH-1:0] wr_data,
    output logic                 wr_ready,
    input  logic [P_SIZE-1:0]    async_rd_gray_ptr,
    output logic [P_SIZE-1:0]    wr_gray_ptr,
    output logic [BUS_WIDTH-1:0] mem_out [F_DEPTH],
    output logic                 full,
    output logic                 almost_full,
    output logic [P_SIZE-1:0]    wr_level,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int AW = P_SIZE - 1;

    logic [P_SIZE-1:0] rd_sync_q [NUM_STAGES];
    logic [P_SIZE-1:0] rd_gray_sync;
    logic [P_SIZE-1:0] rd_bin_sync;
    logic [P_SIZE-1:0] wr_bin;
    logic [AW-1:0]     wr_addr;
    logic              write_en;

    assign rd_gray_sync = rd_sync_q[NUM_STAGES-1];
    assign wr_addr      = wr_bin[AW-1:0];
    assign write_en     = wr_valid && !full;

    // Multi-flop synchronizer for each bit of the incoming read pointer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                rd_sync_q[i] <= '0;
            end
        end else begin
            rd_sync_q[0] <= async_rd_gray_ptr;
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                rd_sync_q[i] <= rd_sync_q[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin_sync = '0;
        for (int unsigned i = 0; i < P_SIZE; i++) begin
            rd_bin_sync[i] = ^(rd_gray_sync >> i);
        end
    end

    // Occupancy and status flags as seen from the write domain.
    always_comb begin
        wr_level    = wr_bin - rd_bin_sync;
        full        = (wr_bin[P_SIZE-1] != rd_bin_sync[P_SIZE-1]) &&
                      (wr_bin[AW-1:0] == rd_bin_sync[AW-1:0]);
        almost_full = (wr_level == P_SIZE'(F_DEPTH - 1));
        wr_ready    = !full;
    end

    // Write pointer; the published Gray copy trails wr_bin by one cycle so the
    // entry is already stable in mem_out when the read side sees the pointer move.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_bin      <= '0;
            wr_gray_ptr <= '0;
        end else begin
            if (write_en) begin
                wr_bin <= wr_bin + P_SIZE'(1);
            end
            wr_gray_ptr <= wr_bin ^ (wr_bin >> 1);
        end
    end

    // Storage: only the addressed entry is written on an accepted write.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < F_DEPTH; i++) begin
                mem_out[i] <= '0;
            end
        end else if (write_en) begin
            mem_out[wr_addr] <= wr_data;
        end
    end

    // Sticky overflow; a set request takes priority over a clear on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/async_fifo_wr_side.md
ASYNC_FIFO_WR_SIDE -- requirements
Module: async_fifo_wr_side

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2: synchronizer depth for the incoming read pointer (minimum 2).
REQ-002 SHALL have parameter BUS_WIDTH, default 66: FIFO entry width in bits.
REQ-003 SHALL have parameter F_DEPTH, default 4: number of entries (power of 2).
REQ-004 SHALL have parameter P_SIZE, default 3: pointer width, log2(F_DEPTH)+1.
REQ-005 SHALL have port CLK, input, 1: write-domain clock.
REQ-006 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port wr_valid, input, 1: producer offers wr_data.
REQ-008 SHALL have port wr_data, input, BUS_WIDTH: entry to write.
REQ-009 SHALL have port wr_ready, output, 1: block accepts wr_data this cycle.
REQ-010 SHALL have port async_rd_gray_ptr, input, P_SIZE: Gray read pointer from the read domain, unsynchronized.
REQ-011 SHALL have port wr_gray_ptr, output, P_SIZE: registered Gray write pointer published to the read domain.
REQ-012 SHALL have port mem_out, output, BUS_WIDTH x F_DEPTH unpacked array: storage contents exported to the read side.
REQ-013 SHALL have port full, output, 1: no free entry.
REQ-014 SHALL have port almost_full, output, 1: exactly one free entry.
REQ-015 SHALL have port wr_level, output, P_SIZE: occupied entries, 0..F_DEPTH, as seen from the write domain.
REQ-016 SHALL have port overflow, output, 1: sticky flag, write attempted while full.
REQ-017 SHALL have port clr_overflow, input, 1: synchronous clear of overflow.

Function
REQ-018 SHALL pass each bit of async_rd_gray_ptr through its own NUM_STAGES-flop chain on CLK; rd_gray_sync is the last stage.
REQ-019 SHALL convert rd_gray_sync to binary rd_bin_sync (bin[P-1]=g[P-1]; bin[i]=bin[i+1]^g[i]).
REQ-020 SHALL hold an internal binary write pointer wr_bin (P_SIZE bits); the low log2(F_DEPTH) bits address storage, the MSB is the wrap bit.
REQ-021 SHALL assert full combinationally when wr_bin[P-1] != rd_bin_sync[P-1] and the low bits are equal.
REQ-022 SHALL compute wr_level = (wr_bin - rd_bin_sync) modulo 2^P_SIZE, combinationally.
REQ-023 SHALL assert almost_full when wr_level == F_DEPTH-1; almost_full and full are never both 1.
REQ-024 SHALL drive wr_ready = !full.
REQ-025 SHALL accept a write on a CLK edge where wr_valid && wr_ready: mem_out[wr_bin low bits] <= wr_data and wr_bin <= wr_bin+1, wrapping 2^P_SIZE-1 -> 0.
REQ-026 SHALL leave storage and wr_bin unchanged when wr_valid is 0 or full is 1.
REQ-027 SHALL update wr_gray_ptr one CLK cycle after the accepting edge, to Gray(wr_bin) = wr_bin ^ (wr_bin>>1), so data is stable in mem_out at least one cycle before the pointer changes.
REQ-028 SHALL change at most one bit of wr_gray_ptr per CLK cycle.
REQ-029 SHALL support back-to-back writes at one per cycle until full.
REQ-030 SHALL recompute full/wr_level from rd_gray_sync every cycle; a read-pointer advance frees entries NUM_STAGES cycles after it appears on async_rd_gray_ptr.
REQ-031 SHALL set overflow on a CLK edge where wr_valid && full; the write is dropped and storage is unchanged.
REQ-032 SHALL clear overflow on a CLK edge where clr_overflow is 1, unless set is also requested on that edge, in which case set wins.
REQ-033 SHALL never modify mem_out entries other than the addressed one.

Reset
REQ-034 SHALL, while RST is 0, asynchronously clear wr_bin, wr_gray_ptr, all synchronizer flops, overflow, and every mem_out entry to 0.
REQ-035 SHALL therefore present, during and immediately after reset, full=0, almost_full=0, wr_level=0, wr_ready=1, overflow=0.
REQ-036 SHALL, on reset assertion mid-write, discard the write; no partial pointer or storage update is retained.

Verification
REQ-037 Defaults, reset, async_rd_gray_ptr=0, write A0..A3 back-to-back -> mem_out[0..3]=A0..A3, wr_level 1,2,3,4, almost_full at level 3, full=1 and wr_ready=0 after 4th write, wr_gray_ptr 001,011,010,110 each one cycle after its write.
REQ-038 Full, wr_valid=1 with A4 -> mem_out unchanged, wr_bin unchanged, overflow=1 next edge; clr_overflow=1 alone -> overflow=0; clr_overflow and write-while-full same edge -> overflow=1.
REQ-039 Full, async_rd_gray_ptr 000->001 -> full drops exactly 2 cycles later, wr_level=3; write A4 -> mem_out[0]=A4, wr_gray_ptr=111.
REQ-040 Wrap: 8 writes with reads tracking -> wr_bin wraps 111->000, wr_gray_ptr 100->000, single-bit Gray changes throughout, no spurious full.
REQ-041 RST=0 asserted while wr_valid=1 mid-burst -> all outputs 0 immediately, wr_ready=1, storage cleared; after release, first write lands in mem_out[0].
